// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, FSM states and GF(2^8) multiply helpers
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // Inverse coefficients are sums of x, 2x, 4x and 8x.
    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] gf_mulB(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] gf_mulD(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] gf_mulE(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// rtl/mix_columns_iter_if.sv - block handshake bundle; in_key present only with MIXCOL_ADDKEY_EN
interface mix_columns_iter_if;

    logic                in_valid;
    logic                in_ready;
    aes_pkg::aes_state_t in_state;
    logic                in_inv;
`ifdef MIXCOL_ADDKEY_EN
    aes_pkg::aes_state_t in_key;
`endif
    logic                out_valid;
    logic                out_ready;
    aes_pkg::aes_state_t out_state;

    modport master (
`ifdef MIXCOL_ADDKEY_EN
        output in_key,
`endif
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
`ifdef MIXCOL_ADDKEY_EN
        input  in_key,
`endif
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state
    );

endinterface

// File: rtl/mix_column_unit.sv
// rtl/mix_column_unit.sv - combinational MixColumns / InvMixColumns on one 32-bit column
module mix_column_unit
    import aes_pkg::*;
(
    input  aes_col_t col_i,
    input  logic     inv_i,
    output aes_col_t col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] f0, f1, f2, f3;
    logic [7:0] r0, r1, r2, r3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign f0 = gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3;
    assign f1 = a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
    assign f2 = a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3);
    assign f3 = gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3);

    assign r0 = gf_mulE(a0) ^ gf_mulB(a1) ^ gf_mulD(a2) ^ gf_mul9(a3);
    assign r1 = gf_mul9(a0) ^ gf_mulE(a1) ^ gf_mulB(a2) ^ gf_mulD(a3);
    assign r2 = gf_mulD(a0) ^ gf_mul9(a1) ^ gf_mulE(a2) ^ gf_mulB(a3);
    assign r3 = gf_mulB(a0) ^ gf_mulD(a1) ^ gf_mul9(a2) ^ gf_mulE(a3);

    assign col_o = inv_i ? {r0, r1, r2, r3} : {f0, f1, f2, f3};

endmodule

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative MixColumns engine, COLS_PER_CYCLE columns per clock
// Optional fused AddRoundKey enabled by defining MIXCOL_ADDKEY_EN.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    mix_columns_iter_if.slave bus,
    output logic              busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
    // With 4 columns per cycle the step wraps to 0, which is harmless: the first group is the last.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);

    mc_state_e  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    aes_state_t work_q, work_d;
    logic       inv_q, inv_d;
`ifdef MIXCOL_ADDKEY_EN
    aes_state_t key_q, key_d;
`endif

    aes_col_t   cols_q   [4];
    aes_col_t   cols_new [4];
    aes_col_t   unit_out [COLS_PER_CYCLE];
    aes_state_t work_xf;
    aes_state_t result;
    logic       accept;
    logic       xfer;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cols_q[i] = work_q[127 - 32*i -: 32];
        end
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
        mix_column_unit u_col (
            .col_i (cols_q[cnt_q + 2'(k)]),
            .inv_i (inv_q),
            .col_o (unit_out[k])
        );
    end

    // Only the current column group is replaced; the rest of the state passes through.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cols_new[i] = cols_q[i];
        end
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            cols_new[cnt_q + 2'(k)] = unit_out[k];
        end
        work_xf = '0;
        for (int i = 0; i < 4; i++) begin
            work_xf[127 - 32*i -: 32] = cols_new[i];
        end
    end

    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign busy          = (state_q == BUSY);
    assign accept        = bus.in_valid && bus.in_ready;
    assign xfer          = bus.out_valid && bus.out_ready;

`ifdef MIXCOL_ADDKEY_EN
    assign result = work_q ^ key_q;
`else
    assign result = work_q;
`endif

    // The working register holds partial results while busy, so the output is gated to DONE.
    assign bus.out_state = (state_q == DONE) ? result : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        inv_d   = inv_q;
`ifdef MIXCOL_ADDKEY_EN
        key_d   = key_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d = work_xf;
                cnt_d  = cnt_q + STEP;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (xfer) begin
                    state_d = accept ? BUSY : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            cnt_d  = '0;
            work_d = bus.in_state;
            inv_d  = bus.in_inv;
`ifdef MIXCOL_ADDKEY_EN
            key_d  = bus.in_key;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            inv_q   <= 1'b0;
`ifdef MIXCOL_ADDKEY_EN
            key_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            inv_q   <= inv_d;
`ifdef MIXCOL_ADDKEY_EN
            key_q   <= key_d;
`endif
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - directed-vector bench for mix_columns_iter at 1, 2 and 4 columns per cycle
module tb_mix_columns_iter;

    localparam logic [127:0] VA = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] VB = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] VC = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] VD = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] VK = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] VAK = 128'ha49c7ff2689f352b6b5bea43026a5049;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid_a  [3];
    logic         in_inv_a    [3];
    logic [127:0] in_state_a  [3];
    logic [127:0] in_key_a    [3];
    logic         out_ready_a [3];
    logic         in_ready_a  [3];
    logic         out_valid_a [3];
    logic         busy_a      [3];
    logic [127:0] out_state_a [3];

    int vectors;
    int miscompares;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_iter_if bus ();
        assign bus.in_valid  = in_valid_a[g];
        assign bus.in_inv    = in_inv_a[g];
        assign bus.in_state  = in_state_a[g];
        assign bus.out_ready = out_ready_a[g];
`ifdef MIXCOL_ADDKEY_EN
        assign bus.in_key    = in_key_a[g];
`endif
        assign in_ready_a[g]  = bus.in_ready;
        assign out_valid_a[g] = bus.out_valid;
        assign out_state_a[g] = bus.out_state;

        mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus),
            .busy (busy_a[g])
        );
    end

    function automatic int lat_of(input int k);
        return 4 >> k;
    endfunction

    // Present one block, wait for acceptance, then scramble the inputs to prove they are latched.
    task automatic send(input int k, input logic [127:0] st, input logic inv,
                        input logic [127:0] key, output bit ok);
        int n = 0;
        in_valid_a[k] = 1'b1;
        in_state_a[k] = st;
        in_inv_a[k]   = inv;
        in_key_a[k]   = key;
        while (!in_ready_a[k] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = in_ready_a[k];
        @(posedge clk); #1;
        in_valid_a[k] = 1'b0;
        in_state_a[k] = {$urandom, $urandom, $urandom, $urandom};
        in_key_a[k]   = {$urandom, $urandom, $urandom, $urandom};
        in_inv_a[k]   = ~inv;
    endtask

    task automatic wait_out(input int k, output int lat);
        lat = 0;
        while (!out_valid_a[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid_a[k]) lat = -1;
    endtask

    task automatic drain(input int k);
        out_ready_a[k] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            in_inv_a[k]    = 1'b0;
            in_state_a[k]  = '0;
            in_key_a[k]    = '0;
            out_ready_a[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (out_valid_a[k] !== 1'b0 || busy_a[k] !== 1'b0 || in_ready_a[k] !== 1'b1 ||
                out_state_a[k] !== 128'h0) begin
                miscompares++;
                $display("FAIL reset[%0d]: out_valid=%b busy=%b in_ready=%b out_state=%h, want 0 0 1 0",
                         k, out_valid_a[k], busy_a[k], in_ready_a[k], out_state_a[k]);
            end
        end
    endtask

    typedef struct {
        int           k;
        logic         inv;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    task automatic test_vectors;
        vec_t tbl [10];
        bit   ok;
        int   lat;
        tbl[0] = '{0, 1'b0, VA, VB};
        tbl[1] = '{1, 1'b1, VB, VA};
        tbl[2] = '{2, 1'b1, VB, VA};
        tbl[3] = '{1, 1'b0, VA, VB};
        tbl[4] = '{2, 1'b0, VA, VB};
        tbl[5] = '{0, 1'b1, VB, VA};
        tbl[6] = '{0, 1'b0, VC, VD};
        tbl[7] = '{0, 1'b1, VD, VC};
        tbl[8] = '{2, 1'b0, VC, VD};
        tbl[9] = '{1, 1'b1, VD, VC};
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].k, tbl[i].din, tbl[i].inv, 128'h0, ok);
            vectors++;
            if (!ok || busy_a[tbl[i].k] !== 1'b1) begin
                miscompares++;
                $display("FAIL vec%0d accept: ok=%0d busy=%b, want 1 1", i, ok, busy_a[tbl[i].k]);
            end
            wait_out(tbl[i].k, lat);
            vectors++;
            if (lat != lat_of(tbl[i].k)) begin
                miscompares++;
                $display("FAIL vec%0d latency: got %0d, want %0d", i, lat, lat_of(tbl[i].k));
            end
            vectors++;
            if (out_state_a[tbl[i].k] !== tbl[i].dout) begin
                miscompares++;
                $display("FAIL vec%0d out_state: got %h, want %h", i, out_state_a[tbl[i].k], tbl[i].dout);
            end
            drain(tbl[i].k);
            vectors++;
            if (out_valid_a[tbl[i].k] !== 1'b0 || in_ready_a[tbl[i].k] !== 1'b1) begin
                miscompares++;
                $display("FAIL vec%0d after transfer: out_valid=%b in_ready=%b, want 0 1",
                         i, out_valid_a[tbl[i].k], in_ready_a[tbl[i].k]);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int lat;
        send(0, VA, 1'b0, 128'h0, ok);
        wait_out(0, lat);
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (out_valid_a[0] !== 1'b1 || out_state_a[0] !== VB || in_ready_a[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL stall c%0d: out_valid=%b in_ready=%b out_state=%h, want 1 0 %h",
                         c, out_valid_a[0], in_ready_a[0], out_state_a[0], VB);
            end
            @(posedge clk); #1;
        end
        in_valid_a[0]  = 1'b1;
        in_state_a[0]  = VC;
        in_inv_a[0]    = 1'b0;
        in_key_a[0]    = '0;
        out_ready_a[0] = 1'b1;
        #1;
        vectors++;
        if (in_ready_a[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL overlap in_ready: got %b, want 1", in_ready_a[0]);
        end
        @(posedge clk); #1;
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b0;
        vectors++;
        if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL overlap state: out_valid=%b busy=%b, want 0 1", out_valid_a[0], busy_a[0]);
        end
        wait_out(0, lat);
        vectors++;
        if (lat != 4 || out_state_a[0] !== VD) begin
            miscompares++;
            $display("FAIL overlap result: lat=%0d out_state=%h, want 4 %h", lat, out_state_a[0], VD);
        end
        drain(0);
    endtask

    task automatic test_back_to_back;
        int acc_cyc [$];
        bit acc;
        in_valid_a[1]  = 1'b1;
        in_state_a[1]  = VA;
        in_inv_a[1]    = 1'b0;
        in_key_a[1]    = '0;
        out_ready_a[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            acc = in_ready_a[1];
            @(posedge clk); #1;
            if (acc) acc_cyc.push_back(i);
            if (out_valid_a[1]) begin
                vectors++;
                if (out_state_a[1] !== VB) begin
                    miscompares++;
                    $display("FAIL b2b out_state c%0d: got %h, want %h", i, out_state_a[1], VB);
                end
            end
        end
        in_valid_a[1] = 1'b0;
        vectors++;
        if (acc_cyc.size() != 4) begin
            miscompares++;
            $display("FAIL b2b accepts: got %0d, want 4", acc_cyc.size());
        end
        for (int j = 1; j < acc_cyc.size(); j++) begin
            vectors++;
            if (acc_cyc[j] - acc_cyc[j-1] != 3) begin
                miscompares++;
                $display("FAIL b2b spacing %0d: got %0d, want 3", j, acc_cyc[j] - acc_cyc[j-1]);
            end
        end
        repeat (4) @(posedge clk);
        #1 out_ready_a[1] = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int lat;
        send(0, VA, 1'b0, 128'h0, ok);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (out_valid_a[0] !== 1'b0 || out_state_a[0] !== 128'h0 || in_ready_a[0] !== 1'b1 ||
            busy_a[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid-reset: out_valid=%b in_ready=%b busy=%b out_state=%h, want 0 1 0 0",
                     out_valid_a[0], in_ready_a[0], busy_a[0], out_state_a[0]);
        end
        send(0, VC, 1'b0, 128'h0, ok);
        wait_out(0, lat);
        vectors++;
        if (!ok || lat != 4 || out_state_a[0] !== VD) begin
            miscompares++;
            $display("FAIL post-reset block: ok=%0d lat=%0d out_state=%h, want 1 4 %h",
                     ok, lat, out_state_a[0], VD);
        end
        drain(0);
    endtask

`ifdef MIXCOL_ADDKEY_EN
    task automatic test_addkey;
        bit ok;
        int lat;
        for (int k = 0; k < 3; k++) begin
            send(k, VA, 1'b0, VK, ok);
            wait_out(k, lat);
            vectors++;
            if (!ok || lat != lat_of(k) || out_state_a[k] !== VAK) begin
                miscompares++;
                $display("FAIL addkey[%0d]: ok=%0d lat=%0d out_state=%h, want 1 %0d %h",
                         k, ok, lat, out_state_a[k], lat_of(k), VAK);
            end
            drain(k);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef MIXCOL_ADDKEY_EN
        test_addkey();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Iterative, parametrised AES MixColumns engine with a valid/ready handshake on both sides.
- Performs forward MixColumns (encrypt) or InvMixColumns (decrypt), selected per block.
- Processes COLS_PER_CYCLE columns per clock; trades area against latency.
- Sits between the ShiftRows/InvShiftRows stage and the AddRoundKey stage of the round datapath.

Parameters:
- COLS_PER_CYCLE, 1: columns transformed per clock; legal values 1, 2, 4. Any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_state/in_inv are valid.
- in_ready  out  1  block can accept a new state.
- in_state  in  128  AES state, bits [0:127], big-endian byte order; column c = bits [32c:32c+31]; byte r of column c = bits [32c+8r:32c+8r+7].
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled at accept.
- out_valid  out  1  out_state is valid.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  128  transformed state, same byte order as in_state.
- busy  out  1  high in BUSY state.

Behaviour:
- Accept occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
- State machine:
  - IDLE: in_ready=1. On accept, latch state and mode, clear column counter, go to BUSY.
  - BUSY: each cycle, transform columns [cnt .. cnt+COLS_PER_CYCLE-1] in place and advance cnt by COLS_PER_CYCLE. After the final group, go to DONE.
  - DONE: out_valid=1, out_state holds the result.
    - Transfer with no new accept: go to IDLE.
    - Transfer with simultaneous accept: go directly to BUSY.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A new block can be accepted on the same edge the previous result leaves.
- Latency: out_valid rises 4/COLS_PER_CYCLE cycles after the accept edge (4, 2, or 1 cycles). Sustained throughput is one block per 4/COLS_PER_CYCLE+1 cycles when out_ready is held high.
- Backpressure: in DONE with out_ready=0, out_state and out_valid hold stable and in_ready=0.
- Arithmetic is in GF(2^8) with polynomial 0x11B.
  - xtime(x) = (x<<1) ^ (x[msb] ? 0x1B : 0x00).
  - Forward matrix rows: [2 3 1 1], [1 2 3 1], [1 1 2 3], [3 1 1 2].
  - Inverse matrix rows: [E B D 9], [9 E B D], [D 9 E B], [B D 9 E].
  - Multiplications by 9, B, D and E are built from chained xtime and XOR. No lookup tables.
- Mode is latched at accept. in_inv changes during BUSY have no effect.
- Reset values: state=IDLE, cnt=0, out_valid=0, busy=0, out_state=128'h0. in_ready=1 from the first cycle after reset.
- Reset mid-operation (BUSY or DONE) aborts the block. No partial result is ever presented.
- in_state is not required to be held after accept.

Optional Feature:
- Macro: MIXCOL_ADDKEY_EN.
- When defined:
  - Add input port in_key [0:127], latched at accept.
  - out_state = MixColumns-result XOR key, i.e. AddRoundKey is fused in.
  - Latency and handshake are unchanged.
- When undefined: no in_key port; out_state is the plain MixColumns/InvMixColumns result.

Decomposition:
- Shared package aes_pkg holds:
  - constant AES_POLY = 8'h1B
  - typedef for a 128-bit state and a 32-bit column
  - functions xtime, gf_mul2, gf_mul3, gf_mul9, gf_mulB, gf_mulD, gf_mulE
  - state enum {IDLE, BUSY, DONE}
- One combinational sub-module, mix_column_unit (32-bit column in, inv in, 32-bit column out), instantiated COLS_PER_CYCLE times.

Test Plan:
- Forward, COLS_PER_CYCLE=1: in_state=d4bf5d30e0b452aeb84111f11e2798e5, in_inv=0 -> out_state=046681e5e0cb199a48f8d37a2806264c, out_valid exactly 4 cycles after accept.
- Inverse on the same block with COLS_PER_CYCLE=2 and 4: 046681e5e0cb199a48f8d37a2806264c, in_inv=1 -> d4bf5d30e0b452aeb84111f11e2798e5, latency 2 and 1 respectively.
- Column vectors: db135345f20a225c01010101c6c6c6c6 -> 8e4da1bc9fdc589d01010101c6c6c6c6 (forward); inverse of the result returns the input.
- Backpressure/back-to-back: hold out_ready=0 for 5 cycles in DONE -> out_state stable, in_ready=0. Then raise out_ready with in_valid=1 -> transfer and accept on the same edge, next result correct.
- Reset mid-BUSY after 2 columns: rst=1 for 1 cycle -> out_valid=0, out_state=0, in_ready=1. A following block completes correctly.
- MIXCOL_ADDKEY_EN defined: block 1 with in_key=a0fafe1788542cb123a339392a6c7605 -> out_state=a49c7ff2689f352b6b5bea43026a5049.
